// File: rtl/adder_sweep_checker.sv
// -----------------------------------------------------------------------------
// adder_sweep_checker
//   On-chip self-test initiator/checker for the 2-bit-field logic block.
//   Sweeps the 8-bit stimulus {d,c,b,a} through 0..255, holds each value for
//   SETTLE_CYC cycles, then compares the block's response {v,z,y,x} against an
//   internal golden model. Reports pass/fail, a saturating error count and the
//   first failing vector.
//
// Ports
//   i_clk         system clock, rising edge
//   i_rst_n       asynchronous reset, active-low
//   i_ena         clock enable; low freezes all state and outputs
//   i_start       1-cycle pulse, begins a sweep when idle
//   i_resp_in     block outputs: [1:0]=x [3:2]=y [5:4]=z [7:6]=v
//   o_stim_out    block inputs:  [1:0]=a [3:2]=b [5:4]=c [7:6]=d
//   o_busy        sweep in progress (DRIVE/CHECK)
//   o_done        1-cycle pulse, sweep finished
//   o_pass        last sweep had zero mismatches (sticky until next start)
//   o_err_count   mismatching vectors in last sweep, saturating
//   o_fail_seen   at least one mismatch in last sweep
//   o_first_fail  stimulus of the first mismatch (valid when o_fail_seen)
// -----------------------------------------------------------------------------
module adder_sweep_checker #(
  parameter int SETTLE_CYC = 1,
  parameter int CNT_W      = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_ena,
  input  logic             i_start,
  input  logic [7:0]       i_resp_in,
  output logic [7:0]       o_stim_out,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [CNT_W-1:0] o_err_count,
  output logic             o_fail_seen,
  output logic [7:0]       o_first_fail
);

  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_CHECK,
    S_FINISH
  } state_t;

  state_t             r_state, w_state_next;
  logic [7:0]         r_vec, w_vec_next;
  logic [SET_W-1:0]   r_settle, w_settle_next;
  logic [CNT_W-1:0]   r_err, w_err_next;
  logic               r_fail_seen, w_fail_seen_next;
  logic [7:0]         r_first_fail, w_first_fail_next;
  logic               r_pass, w_pass_next;

  // Golden model: each field is 2 bits wide and the equations apply bitwise.
  logic [1:0] w_a, w_b, w_c, w_d;
  logic [7:0] w_exp;
  logic       w_mismatch;

  assign w_a = r_vec[1:0];
  assign w_b = r_vec[3:2];
  assign w_c = r_vec[5:4];
  assign w_d = r_vec[7:6];

  assign w_exp = { (w_a & w_b) | (~w_c & w_d),   // v
                   w_a & ~w_b & w_c & w_d,       // z
                   w_a & w_b & w_c & w_d,        // y
                   w_a & w_b & ~w_c & w_d };     // x

  assign w_mismatch = (i_resp_in != w_exp);

  always_comb begin
    w_state_next      = r_state;
    w_vec_next        = r_vec;
    w_settle_next     = r_settle;
    w_err_next        = r_err;
    w_fail_seen_next  = r_fail_seen;
    w_first_fail_next = r_first_fail;
    w_pass_next       = r_pass;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_err_next        = '0;
          w_fail_seen_next  = 1'b0;
          w_first_fail_next = 8'h00;
          w_pass_next       = 1'b0;
          w_vec_next        = 8'h00;
          w_settle_next     = '0;
          w_state_next      = S_DRIVE;
        end
      end

      S_DRIVE: begin
        if (r_settle == SETTLE_LAST) begin
          w_state_next = S_CHECK;
        end else begin
          w_settle_next = r_settle + SET_W'(1);
        end
      end

      S_CHECK: begin
        if (w_mismatch) begin
          if (r_err != {CNT_W{1'b1}}) begin
            w_err_next = r_err + CNT_W'(1);
          end
          if (!r_fail_seen) begin
            w_first_fail_next = r_vec;
            w_fail_seen_next  = 1'b1;
          end
        end
        if (r_vec == 8'hFF) begin
          // Latch the verdict on entry to FINISH so pass lines up with done,
          // including a mismatch on the very last vector.
          w_pass_next  = !w_fail_seen_next;
          w_state_next = S_FINISH;
        end else begin
          w_vec_next    = r_vec + 8'd1;
          w_settle_next = '0;
          w_state_next  = S_DRIVE;
        end
      end

      S_FINISH: begin
        w_state_next = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_vec        <= 8'h00;
      r_settle     <= '0;
      r_err        <= '0;
      r_fail_seen  <= 1'b0;
      r_first_fail <= 8'h00;
      r_pass       <= 1'b0;
    end else if (i_ena) begin
      r_state      <= w_state_next;
      r_vec        <= w_vec_next;
      r_settle     <= w_settle_next;
      r_err        <= w_err_next;
      r_fail_seen  <= w_fail_seen_next;
      r_first_fail <= w_first_fail_next;
      r_pass       <= w_pass_next;
    end
  end

  assign o_stim_out   = r_vec;
  assign o_busy       = (r_state == S_DRIVE) || (r_state == S_CHECK);
  assign o_done       = (r_state == S_FINISH);
  assign o_pass       = r_pass;
  assign o_err_count  = r_err;
  assign o_fail_seen  = r_fail_seen;
  assign o_first_fail = r_first_fail;

endmodule

// File: tb/tb_adder_sweep_checker.sv
// -----------------------------------------------------------------------------
// tb_adder_sweep_checker
//   Self-checking bench: a table of directed sweeps (golden block, tied
//   responses, single-vector faults), randomized fault/enable sweeps checked
//   against a scoreboard, and hand-written reset / freeze sequences.
// -----------------------------------------------------------------------------
module tb_adder_sweep_checker;

  localparam int SWEEP_EDGES = 512;   // 256 vectors * (SETTLE_CYC + 1)

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       start;
  logic [7:0] resp_in;
  logic [7:0] stim_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_count;
  logic       fail_seen;
  logic [7:0] first_fail;

  adder_sweep_checker #(.SETTLE_CYC(1), .CNT_W(8)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_ena        (ena),
    .i_start      (start),
    .i_resp_in    (resp_in),
    .o_stim_out   (stim_out),
    .o_busy       (busy),
    .o_done       (done),
    .o_pass       (pass),
    .o_err_count  (err_count),
    .o_fail_seen  (fail_seen),
    .o_first_fail (first_fail)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model of the logic block, evaluated bit position by bit position
  // with integer arithmetic straight from the field equations.
  function automatic logic [7:0] ref_resp(input int s);
    int a, b, c, d, r;
    r = 0;
    for (int k = 0; k < 2; k++) begin
      a = (s >> k) & 1;
      b = (s >> (2 + k)) & 1;
      c = (s >> (4 + k)) & 1;
      d = (s >> (6 + k)) & 1;
      r += (a * b * (1 - c) * d) << k;
      r += (a * b * c * d) << (2 + k);
      r += (a * (1 - b) * c * d) << (4 + k);
      r += (((a * b + (1 - c) * d) > 0) ? 1 : 0) << (6 + k);
    end
    return 8'(r);
  endfunction

  // Stimulus-side response source: tied value, spot constants, or the
  // fault-free block with an optional per-vector corruption mask.
  logic       tie_en;
  logic [7:0] tie_val;
  logic       spot_en;
  logic [7:0] flip_mask [256];

  function automatic logic [7:0] tb_resp(input logic [7:0] v, input logic te,
                                         input logic [7:0] tv, input logic se,
                                         input logic [7:0] m);
    if (te) return tv;
    if (se) begin
      if (v == 8'hFF) return 8'hCC;
      if (v == 8'hC3) return 8'hC0;
      if (v == 8'h00) return 8'h00;
    end
    return ref_resp(int'(v)) ^ m;
  endfunction

  always_comb begin
    resp_in = tb_resp(stim_out, tie_en, tie_val, spot_en, flip_mask[stim_out]);
  end

  task automatic clear_faults();
    tie_en  = 1'b0;
    tie_val = 8'h00;
    spot_en = 1'b0;
    for (int i = 0; i < 256; i++) flip_mask[i] = 8'h00;
  endtask

  // Scoreboard: walk all vectors as the checker should, using the current setup.
  task automatic score(output int exp_err, output int exp_first, output bit exp_fail);
    logic [7:0] r;
    exp_err = 0; exp_first = 0; exp_fail = 1'b0;
    for (int v = 0; v < 256; v++) begin
      r = tb_resp(8'(v), tie_en, tie_val, spot_en, flip_mask[v]);
      if (r != ref_resp(v)) begin
        if (!exp_fail) exp_first = v;
        exp_fail = 1'b1;
        if (exp_err < 255) exp_err++;
      end
    end
  endtask

  // One full sweep from IDLE. Optional random enable gaps, a forced freeze
  // window (with a start pulse inside it) and a start pulse while busy.
  task automatic run_sweep(input string tag, input int gap_pct,
                           input int freeze_at, input int freeze_len,
                           input int busy_start_at, input int exp_err,
                           input int exp_first, input bit exp_fail,
                           output int total);
    int         active;
    logic [7:0] snap;
    ena = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    active = 0; total = 0; snap = 8'h00;
    while (done !== 1'b1 && total < 3000) begin
      if (total >= freeze_at && total < freeze_at + freeze_len) ena = 1'b0;
      else if (gap_pct > 0 && $urandom_range(99) < gap_pct) ena = 1'b0;
      else ena = 1'b1;
      if (total == freeze_at) snap = stim_out;
      start = (total == freeze_at + 5) || (total == busy_start_at);
      @(posedge clk); #1;
      start = 1'b0;
      total++;
      if (ena) active++;
      if (total == 10) check({tag, "_busy_mid"}, int'(busy), 1);
      if (freeze_len > 0 && total == freeze_at + freeze_len)
        check({tag, "_stim_frozen"}, int'(stim_out), int'(snap));
    end
    ena = 1'b1;
    check({tag, "_done_seen"}, int'(done === 1'b1), 1);
    check({tag, "_latency"}, active, SWEEP_EDGES);
    check({tag, "_busy_fin"}, int'(busy), 0);
    check({tag, "_pass"}, int'(pass), int'(!exp_fail));
    check({tag, "_err_count"}, int'(err_count), exp_err);
    check({tag, "_fail_seen"}, int'(fail_seen), int'(exp_fail));
    if (exp_fail) check({tag, "_first_fail"}, int'(first_fail), exp_first);
    check({tag, "_stim_ff"}, int'(stim_out), 8'hFF);
    // start in the done cycle must be ignored
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_done_pulse"}, int'(done), 0);
    check({tag, "_start_at_done_ignored"}, int'(busy), 0);
    check({tag, "_pass_sticky"}, int'(pass), int'(!exp_fail));
    $display("sweep %s: err_count=%0d first_fail=0x%02h pass=%0d edges=%0d",
             tag, err_count, first_fail, pass, total);
  endtask

  typedef struct {
    string      name;
    bit         tie_en;
    logic [7:0] tie_val;
    bit         spot_en;
    int         flip_vec;
    logic [7:0] flip_val;
    int         exp_err;
    int         exp_first;
    bit         exp_fail;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int total, e_err, e_first, nflip;
    bit e_fail;

    tbl[0] = '{"golden",    1'b0, 8'h00, 1'b0, -1,    8'h00, 0,   0,    1'b0};
    tbl[1] = '{"spot",      1'b0, 8'h00, 1'b1, -1,    8'h00, 0,   0,    1'b0};
    tbl[2] = '{"tie00",     1'b1, 8'h00, 1'b0, -1,    8'h00, 192, 8'h05, 1'b1};
    tbl[3] = '{"tieFF",     1'b1, 8'hFF, 1'b0, -1,    8'h00, 255, 8'h00, 1'b1};
    tbl[4] = '{"flip80",    1'b0, 8'h00, 1'b0, 8'h80, 8'h01, 1,   8'h80, 1'b1};
    tbl[5] = '{"flipFF",    1'b0, 8'h00, 1'b0, 8'hFF, 8'h30, 1,   8'hFF, 1'b1};
    tbl[6] = '{"flip00",    1'b0, 8'h00, 1'b0, 8'h00, 8'hC0, 1,   8'h00, 1'b1};

    clear_faults();
    rst_n = 1'b0; ena = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_stim", int'(stim_out), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_pass", int'(pass), 0);
    check("reset_err", int'(err_count), 0);
    check("reset_fail_seen", int'(fail_seen), 0);
    check("reset_first_fail", int'(first_fail), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_no_start_busy", int'(busy), 0);

    // Directed table
    for (int i = 0; i < 7; i++) begin
      clear_faults();
      tie_en  = tbl[i].tie_en;
      tie_val = tbl[i].tie_val;
      spot_en = tbl[i].spot_en;
      if (tbl[i].flip_vec >= 0) flip_mask[tbl[i].flip_vec] = tbl[i].flip_val;
      run_sweep(tbl[i].name, 0, 100000, 0, -1, tbl[i].exp_err,
                tbl[i].exp_first, tbl[i].exp_fail, total);
      check({tbl[i].name, "_edges"}, total, SWEEP_EDGES);
    end

    // Randomized fault masks and enable gaps against the scoreboard
    for (int it = 0; it < 5; it++) begin
      clear_faults();
      nflip = (it == 4) ? $urandom_range(20, 60) : $urandom_range(0, 6);
      for (int f = 0; f < nflip; f++)
        flip_mask[$urandom_range(255)] = 8'($urandom_range(1, 255));
      score(e_err, e_first, e_fail);
      run_sweep($sformatf("rand%0d", it), 20, 100000, 0, -1,
                e_err, e_first, e_fail, total);
    end

    // Reset dropped while vector 0x80 is under test
    clear_faults();
    tie_en = 1'b1; tie_val = 8'h00;   // make err/fail state non-zero first
    ena = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 400 && stim_out != 8'h80; c++) begin
      @(posedge clk); #1;
    end
    check("rst_reached_80", int'(stim_out), 8'h80);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_stim", int'(stim_out), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_err", int'(err_count), 0);
    check("async_rst_fail_seen", int'(fail_seen), 0);
    check("async_rst_first_fail", int'(first_fail), 0);
    check("async_rst_pass", int'(pass), 0);
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_no_done", int'(done), 0);
    end
    rst_n = 1'b1;
    clear_faults();
    run_sweep("after_reset", 0, 100000, 0, -1, 0, 0, 1'b0, total);

    // 20-cycle enable freeze mid-sweep plus start pulses while busy
    run_sweep("freeze", 0, 150, 20, 300, 0, 0, 1'b0, total);
    check("freeze_edges", total, SWEEP_EDGES + 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
